// File: rtl/frame_burst_sched.sv
// Frame burst scheduler: walks a frame of lines, each made of full bursts plus an
// optional tail burst, handshaking every burst with an AXI master.
module frame_burst_sched #(
    parameter int LSIZE = 16,
    parameter int BSIZE = 12
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             frame_start,
    input  logic             abort,
    input  logic [LSIZE-1:0] frame_lines,
    input  logic [BSIZE-1:0] line_bursts,
    input  logic             line_tail,
    output logic             req,
    output logic             req_tail,
    input  logic             ack,
    input  logic             wdone,
    output logic             new_base,
    output logic             burst_done,
    output logic             tail_done,
    output logic             busy,
    output logic             frame_done,
    output logic [LSIZE-1:0] line_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_REQ,
        S_WAIT,
        S_STEP,
        S_GAP1,
        S_GAP2,
        S_DONE
    } state_t;

    localparam logic [LSIZE-1:0] L_ONE = LSIZE'(1);
    localparam logic [BSIZE:0]   B_ONE = (BSIZE + 1)'(1);

    state_t           state_q, state_d;
    logic [LSIZE-1:0] lines_q, lines_d;
    logic [BSIZE-1:0] bursts_q, bursts_d;
    logic             tail_q, tail_d;
    logic [LSIZE-1:0] line_q, line_d;
    logic [BSIZE:0]   burst_q, burst_d;

    logic [BSIZE:0]   n_last;
    logic             last_burst;
    logic             last_line;

    // Index of the last burst in a line; only consulted once N>0 is guaranteed.
    assign n_last     = {1'b0, bursts_q} + {{BSIZE{1'b0}}, tail_q} - B_ONE;
    assign last_burst = (burst_q == n_last);
    assign last_line  = (line_q == lines_q - L_ONE);

    always_comb begin
        state_d  = state_q;
        lines_d  = lines_q;
        bursts_d = bursts_q;
        tail_d   = tail_q;
        line_d   = line_q;
        burst_d  = burst_q;
        case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    state_d  = S_LOAD;
                    lines_d  = frame_lines;
                    bursts_d = line_bursts;
                    tail_d   = line_tail;
                    line_d   = '0;
                    burst_d  = '0;
                end
            end
            S_LOAD: begin
                if (lines_q == '0 || (bursts_q == '0 && !tail_q)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_REQ:  if (ack) state_d = S_WAIT;
            S_WAIT: if (wdone) state_d = S_STEP;
            S_STEP: state_d = S_GAP1;
            S_GAP1: state_d = S_GAP2;
            S_GAP2: begin
                if (!last_burst) begin
                    burst_d = burst_q + B_ONE;
                    state_d = S_REQ;
                end else if (!last_line) begin
                    burst_d = '0;
                    line_d  = line_q + L_ONE;
                    state_d = S_REQ;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Abort wins over everything once a frame is in flight.
        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            lines_q  <= '0;
            bursts_q <= '0;
            tail_q   <= 1'b0;
            line_q   <= '0;
            burst_q  <= '0;
        end else begin
            state_q  <= state_d;
            lines_q  <= lines_d;
            bursts_q <= bursts_d;
            tail_q   <= tail_d;
            line_q   <= line_d;
            burst_q  <= burst_d;
        end
    end

    // Outputs decode registered state only, so ack/wdone never reach them combinationally.
    assign req        = (state_q == S_REQ);
    assign req_tail   = (state_q == S_REQ) && tail_q && last_burst;
    assign new_base   = (state_q == S_LOAD);
    assign burst_done = (state_q == S_STEP) && !last_burst;
    assign tail_done  = (state_q == S_STEP) && last_burst;
    assign busy       = (state_q != S_IDLE);
    assign frame_done = (state_q == S_DONE);
    assign line_cnt   = line_q;

endmodule
